signal_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the state monitor: takes the raw asynchronous sensor line and delivers a synchronized, debounced level to the monitor's signal input.
- Also emits one-cycle rise/fall pulses.
- Counts rejected glitches so firmware/test pins can observe input quality.
- Runs on the same slow (10 kHz) system clock as the monitor.

---
 rtl/signal_conditioner.sv | 128 ++++++++++++
 tb/tb_signal_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_conditioner.sv
// Sensor input conditioner: synchronizer, hold-time debounce,
// edge pulses and a saturating glitch counter.
module signal_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int SCALE       = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_signal,
  input  logic       i_enable,
  input  logic [3:0] i_hold,
  input  logic       i_clear_count,
  output logic       o_signal,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_glitch,
  output logic [7:0] o_glitch_count
);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   load_val;
  logic                   sig_q, sig_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;
  logic [7:0]             gcnt_q, gcnt_d;

  logic s_sync;
  logic mismatch;
  logic cnt_zero;
  logic do_load;
  logic do_count;
  logic do_abort;
  logic do_accept;

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign mismatch = s_sync != sig_q;
  assign cnt_zero = cnt_q == '0;
  assign load_val = CNT_WIDTH'(i_hold) * CNT_WIDTH'(SCALE);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_signal};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= STABLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable abandons any qualification without a glitch pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STABLE: begin
        if (i_enable && mismatch) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!i_enable || !mismatch || cnt_zero) state_d = STABLE;
      end
      default: state_d = STABLE;
    endcase
  end

  always_comb begin
    do_load   = (state_q == STABLE) && i_enable && mismatch;
    do_abort  = (state_q == QUALIFY) && i_enable && !mismatch;
    do_accept = (state_q == QUALIFY) && i_enable && mismatch && cnt_zero;
    do_count  = (state_q == QUALIFY) && i_enable && mismatch && !cnt_zero;

    cnt_d = cnt_q;
    if (do_load) begin
      cnt_d = load_val;
    end else if (do_count) begin
      cnt_d = cnt_q - 1'b1;
    end

    sig_d    = do_accept ? s_sync : sig_q;
    rise_d   = do_accept && s_sync;
    fall_d   = do_accept && !s_sync;
    glitch_d = do_abort;

    gcnt_d = gcnt_q;
    unique case (1'b1)
      i_clear_count:                gcnt_d = 8'd0;
      do_abort && gcnt_q != 8'hFF:  gcnt_d = gcnt_q + 8'd1;
      default:                      gcnt_d = gcnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      sig_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      gcnt_q   <= 8'd0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign o_signal       = sig_q;
  assign o_rise         = rise_q;
  assign o_fall         = fall_q;
  assign o_glitch       = glitch_q;
  assign o_glitch_count = gcnt_q;

endmodule

// File: tb/tb_signal_conditioner.sv
// Bench for signal_conditioner: directed scenarios plus random
// glitch trains, checked each cycle against a deadline-based model.
module tb_signal_conditioner;

  localparam int SS    = 2;
  localparam int CW    = 16;
  localparam int SCALE = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig;
  logic       en;
  logic [3:0] hold;
  logic       clr;
  logic       o_signal;
  logic       o_rise;
  logic       o_fall;
  logic       o_glitch;
  logic [7:0] o_glitch_count;

  int checks = 0;
  int errors = 0;

  signal_conditioner #(
    .SYNC_STAGES(SS),
    .CNT_WIDTH  (CW),
    .SCALE      (SCALE)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_signal      (sig),
    .i_enable      (en),
    .i_hold        (hold),
    .i_clear_count (clr),
    .o_signal      (o_signal),
    .o_rise        (o_rise),
    .o_fall        (o_fall),
    .o_glitch      (o_glitch),
    .o_glitch_count(o_glitch_count)
  );

  always #5 clk = ~clk;

  // Reference model: a candidate change started at cycle c with
  // hold h is accepted at cycle c + h*SCALE + 1 unless reverted.
  logic m_pipe[$];
  logic m_sig;
  logic m_qual;
  int   m_deadline;
  int   m_cyc;
  int   m_cnt;
  logic m_rise;
  logic m_fall;
  logic m_glitch;

  function automatic void model_reset();
    m_pipe.delete();
    for (int i = 0; i < SS; i++) m_pipe.push_back(1'b0);
    m_sig      = 1'b0;
    m_qual     = 1'b0;
    m_deadline = 0;
    m_cyc      = 0;
    m_cnt      = 0;
    m_rise     = 1'b0;
    m_fall     = 1'b0;
    m_glitch   = 1'b0;
  endfunction

  function automatic void model_update();
    logic s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m_pipe[$];
    m_cyc++;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_glitch = 1'b0;
    if (!en) begin
      m_qual = 1'b0;
    end else if (!m_qual) begin
      if (s != m_sig) begin
        m_qual     = 1'b1;
        m_deadline = m_cyc + int'(hold) * SCALE + 1;
      end
    end else if (s == m_sig) begin
      m_glitch = 1'b1;
      m_qual   = 1'b0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_cyc == m_deadline) begin
      m_sig  = s;
      m_rise = s;
      m_fall = !s;
      m_qual = 1'b0;
    end
    if (clr) m_cnt = 0;
    m_pipe.push_front(sig);
    void'(m_pipe.pop_back());
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("sig", 32'(o_signal), 32'(m_sig));
    check("rise", 32'(o_rise), 32'(m_rise));
    check("fall", 32'(o_fall), 32'(m_fall));
    check("glitch", 32'(o_glitch), 32'(m_glitch));
    check("gcount", 32'(o_glitch_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic wait_level(input logic v, input int maxn,
                            output int n);
    n = 0;
    while (o_signal !== v && n < maxn) begin
      step();
      n++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sig"}, 32'(o_signal), 32'd0);
    check({tag, "_rise"}, 32'(o_rise), 32'd0);
    check({tag, "_fall"}, 32'(o_fall), 32'd0);
    check({tag, "_glitch"}, 32'(o_glitch), 32'd0);
    check({tag, "_gcount"}, 32'(o_glitch_count), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int w;
    int g;

    rst_n = 1'b0;
    sig   = 1'b0;
    en    = 1'b1;
    hold  = 4'd0;
    clr   = 1'b0;
    model_reset();

    // 1: reset state and minimum latency rise
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    sig = 1'b1;
    wait_level(1'b1, 20, n);
    check("t1_latency", 32'(n), 32'd4);
    check("t1_rise", 32'(o_rise), 32'd1);
    check("t1_gcount", 32'(o_glitch_count), 32'd0);
    step();
    check("t1_rise_one", 32'(o_rise), 32'd0);

    // 2: glitch rejection then full qualification with hold=1
    sig = 1'b0;
    wait_level(1'b0, 20, n);
    check("t2_fall_lat", 32'(n), 32'd4);
    hold = 4'd1;
    sig = 1'b1;
    repeat (50) step();
    sig = 1'b0;
    repeat (10) step();
    check("t2_sig_low", 32'(o_signal), 32'd0);
    check("t2_gcount", 32'(o_glitch_count), 32'd1);
    sig = 1'b1;
    wait_level(1'b1, 300, n);
    check("t2_latency", 32'(n), 32'd104);

    // 3: random glitch train saturates, clear beats increment
    hold = 4'd0;
    sig = 1'b0;
    wait_level(1'b0, 20, n);
    hold = 4'd2;
    for (int i = 0; i < 260; i++) begin
      w = int'($urandom_range(1, 40));
      g = int'($urandom_range(1, 15));
      sig = 1'b1;
      repeat (w) step();
      sig = 1'b0;
      repeat (g) step();
    end
    repeat (5) step();
    check("t3_saturate", 32'(o_glitch_count), 32'd255);
    check("t3_sig", 32'(o_signal), 32'd0);
    sig = 1'b1;
    repeat (5) step();
    sig = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t3_glitch", 32'(o_glitch), 32'd1);
    check("t3_cleared", 32'(o_glitch_count), 32'd0);

    // 4: disable abandons qualification, re-enable restarts it
    hold = 4'd3;
    sig = 1'b1;
    repeat (150) step();
    en = 1'b0;
    repeat (20) step();
    check("t4_frozen", 32'(o_signal), 32'd0);
    check("t4_no_glitch", 32'(o_glitch_count), 32'd0);
    en = 1'b1;
    wait_level(1'b1, 400, n);
    check("t4_restart", 32'(n), 32'd302);

    // 5: hold sampled only at candidate start; fast fall
    hold = 4'd0;
    sig = 1'b0;
    wait_level(1'b0, 20, n);
    hold = 4'd1;
    sig = 1'b1;
    repeat (50) step();
    hold = 4'd15;
    wait_level(1'b1, 200, n);
    check("t5_latency", 32'(n + 50), 32'd104);
    hold = 4'd0;
    sig = 1'b0;
    wait_level(1'b0, 20, n);
    check("t5_fall_lat", 32'(n), 32'd4);
    check("t5_fall", 32'(o_fall), 32'd1);

    // 6: async reset mid-qualification, then requalify from scratch
    hold = 4'd2;
    sig = 1'b1;
    repeat (50) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;
    wait_level(1'b1, 300, n);
    check("t6_requal", 32'(n), 32'd204);
    check("t6_rise", 32'(o_rise), 32'd1);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
